// File: rtl/maxnet_pkg.sv
// maxnet_pkg: fp32 field layout, FSM states and shared helpers for the maxnet winner-take-all block
package maxnet_pkg;
  localparam int SIGN_BIT  = 31;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int MAN_MSB   = 22;
  localparam int MAN_W     = 23;
  localparam int EXP_W     = 8;
  localparam int EPS_SHIFT = 2;
  localparam int ITER_CAP  = 64;
  localparam int ITER_W    = 7;

  typedef enum logic [2:0] {IDLE, ARMED, SUM, UPD, DONE} state_t;

  function automatic logic [31:0] fp_relu(input logic [31:0] v);
    return (v[SIGN_BIT] || v[EXP_MSB:EXP_LSB] == '0) ? 32'h0 : v;
  endfunction

  // Multiply by 2^-EPS_SHIFT; results that would leave the normal range flush to +0
  function automatic logic [31:0] fp_scale_eps(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] <= EXP_W'(EPS_SHIFT)) ? 32'h0 :
           {v[SIGN_BIT], v[EXP_MSB:EXP_LSB] - EXP_W'(EPS_SHIFT), v[MAN_MSB:0]};
  endfunction
endpackage

// File: rtl/fp32_addsub.sv
// fp32_addsub: combinational fp32 add/subtract, round-toward-zero, subnormals flushed to +0
module fp32_addsub
  import maxnet_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_y
);
  logic              w_sb, w_swap, w_sy, w_eff_sub, w_sticky, w_zero, w_unused;
  logic [EXP_W-1:0]  w_ea, w_eb, w_ebig, w_d;
  logic [MAN_W:0]    w_ma, w_mb;
  logic [26:0]       w_big, w_sml, w_sml_sh, w_sml_al, w_norm;
  logic [27:0]       w_r;
  logic [4:0]        w_lz;
  logic signed [9:0] w_e;

  assign w_ea      = i_a[EXP_MSB:EXP_LSB];
  assign w_eb      = i_b[EXP_MSB:EXP_LSB];
  assign w_ma      = (w_ea == '0) ? '0 : {1'b1, i_a[MAN_MSB:0]};
  assign w_mb      = (w_eb == '0) ? '0 : {1'b1, i_b[MAN_MSB:0]};
  assign w_sb      = i_b[SIGN_BIT] ^ i_sub;
  assign w_swap    = {w_eb, w_mb} > {w_ea, w_ma};
  assign w_sy      = w_swap ? w_sb : i_a[SIGN_BIT];
  assign w_eff_sub = i_a[SIGN_BIT] ^ w_sb;
  assign w_ebig    = w_swap ? w_eb : w_ea;
  assign w_d       = w_swap ? w_eb - w_ea : w_ea - w_eb;
  // Three guard bits plus a sticky bit keep truncation exact for both add and subtract
  assign w_big     = {w_swap ? w_mb : w_ma, 3'b000};
  assign w_sml     = {w_swap ? w_ma : w_mb, 3'b000};
  assign w_sml_sh  = w_sml >> w_d;
  assign w_sticky  = |(w_sml & ~(27'h7FFFFFF << w_d));
  assign w_sml_al  = {w_sml_sh[26:1], w_sml_sh[0] | w_sticky};
  assign w_r       = w_eff_sub ? {1'b0, w_big} - {1'b0, w_sml_al} : {1'b0, w_big} + {1'b0, w_sml_al};

  // Leading-zero count of the magnitude below the carry bit
  always_comb begin
    w_lz = 5'd27;
    for (int k = 0; k < 27; k++) if (w_r[k]) w_lz = 5'(26 - k);
  end

  assign w_norm   = w_r[26:0] << w_lz;
  assign w_e      = $signed({2'b00, w_ebig}) + (w_r[27] ? 10'sd1 : -$signed({5'b00000, w_lz}));
  assign w_zero   = (w_r == '0) || (w_e <= 10'sd0);
  assign o_y      = w_zero ? '0 : {w_sy, w_e[7:0], w_r[27] ? w_r[26:4] : w_norm[25:3]};
  assign w_unused = ^{w_norm[26], w_norm[2:0]};
endmodule

// File: rtl/maxnet.sv
// maxnet: four-input fp32 winner-take-all (eps=0.25); define MAXNET_ITER_CAP_EN to stop after ITER_CAP iterations
module maxnet
  import maxnet_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_init_1,
  input  logic [31:0] x_init_2,
  input  logic [31:0] x_init_3,
  input  logic [31:0] x_init_4,
  output logic        done,
  output logic [3:0]  out
);
`ifdef MAXNET_ITER_CAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  state_t            r_state, w_next;
  logic [31:0]       r_x [4];
  logic [31:0]       r_sum;
  logic [ITER_W-1:0] r_iter, w_iter_nxt;
  logic [31:0]       w_init [4];
  logic [31:0]       w_diff [4];
  logic [31:0]       w_upd [4];
  logic [31:0]       w_x_new [4];
  logic [31:0]       w_p01, w_p23, w_sum;
  logic [3:0]        w_nz, w_nz_new;
  logic              w_load, w_last, w_cap;

  assign w_init[0] = x_init_1;
  assign w_init[1] = x_init_2;
  assign w_init[2] = x_init_3;
  assign w_init[3] = x_init_4;

  fp32_addsub u_add01 (.i_a(r_x[0]), .i_b(r_x[1]), .i_sub(1'b0), .o_y(w_p01));
  fp32_addsub u_add23 (.i_a(r_x[2]), .i_b(r_x[3]), .i_sub(1'b0), .o_y(w_p23));
  fp32_addsub u_addsum (.i_a(w_p01), .i_b(w_p23), .i_sub(1'b0), .o_y(w_sum));

  for (genvar g = 0; g < 4; g++) begin : g_neuron
    fp32_addsub u_diff (.i_a(r_sum), .i_b(r_x[g]), .i_sub(1'b1), .o_y(w_diff[g]));
    fp32_addsub u_upd (.i_a(r_x[g]), .i_b(fp_scale_eps(w_diff[g])), .i_sub(1'b1), .o_y(w_upd[g]));
    assign w_x_new[g]  = fp_relu(w_upd[g]);
    assign w_nz[g]     = |r_x[g];
    assign w_nz_new[g] = |w_x_new[g];
  end

  assign w_load     = (r_state == ARMED) && !start;
  assign w_iter_nxt = r_iter + 1'b1;
  assign w_last     = (w_nz_new & (w_nz_new - 4'd1)) == 4'd0;
  assign w_cap      = CAP_EN && (w_iter_nxt == ITER_W'(ITER_CAP));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; start is only honoured in IDLE, ARMED and DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? ARMED : IDLE;
      ARMED:   w_next = start ? ARMED : SUM;
      SUM:     w_next = UPD;
      UPD:     w_next = (w_last || w_cap) ? DONE : SUM;
      DONE:    w_next = start ? ARMED : DONE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: the survivor mask is only exposed while holding the result
  always_comb begin
    done = (r_state == DONE);
    out  = done ? w_nz : 4'd0;
  end

  // Datapath: load clamped inputs, register the tree sum, apply the inhibition update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) r_x[k] <= '0;
      r_sum  <= '0;
      r_iter <= '0;
    end else if (w_load) begin
      for (int k = 0; k < 4; k++) r_x[k] <= fp_relu(w_init[k]);
      r_iter <= '0;
    end else if (r_state == SUM) begin
      r_sum <= w_sum;
    end else if (r_state == UPD) begin
      for (int k = 0; k < 4; k++) r_x[k] <= w_x_new[k];
      r_iter <= w_iter_nxt;
    end
  end
endmodule

// File: tb/tb_maxnet.sv
// tb_maxnet: directed self-checking bench for maxnet
module tb_maxnet;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_init_1 = '0, x_init_2 = '0, x_init_3 = '0, x_init_4 = '0;
  logic        done;
  logic [3:0]  out;
  int          tests = 0;
  int          fails = 0;

  maxnet dut (
    .clk(clk), .rst(rst), .start(start),
    .x_init_1(x_init_1), .x_init_2(x_init_2), .x_init_3(x_init_3), .x_init_4(x_init_4),
    .done(done), .out(out)
  );

  always #5 clk = ~clk;

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                     input logic [31:0] d, input int n, input logic [3:0] eo,
                     input string tag, input bit poke);
    int lat;
    bit seen;
    x_init_1 = a; x_init_2 = b; x_init_3 = c; x_init_4 = d;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    assert (done === 1'b0 && out === 4'b0000)
      else begin fails++; $error("FAIL %s_armed done=%b out=%b expected done=0 out=0000", tag, done, out); end
    start = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        x_init_1 = 32'h3F800000; x_init_2 = 32'h3F800000;
        x_init_3 = 32'h3F800000; x_init_4 = 32'h3F800000;
      end
      if (poke && lat == 4) start = 1'b1;
      if (poke && lat == 6) start = 1'b0;
      seen = done;
    end
    tests++;
    assert (lat === 2 * n + 1)
      else begin fails++; $error("FAIL %s_latency edges=%0d expected %0d", tag, lat, 2 * n + 1); end
    tests++;
    assert (out === eo)
      else begin fails++; $error("FAIL %s_out got=%b expected %b", tag, out, eo); end
    repeat (3) @(negedge clk);
    tests++;
    assert (done === 1'b1 && out === eo)
      else begin fails++; $error("FAIL %s_hold done=%b out=%b expected done=1 out=%b", tag, done, out, eo); end
  endtask

  initial begin
    #3;
    tests++;
    assert (done === 1'b0 && out === 4'b0000)
      else begin fails++; $error("FAIL reset done=%b out=%b expected done=0 out=0000", done, out); end
    @(negedge clk) rst = 1'b1;

    run(32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD, 4, 4'b1000, "ramp", 1'b0);
    run(32'hB24CDCCD, 32'h3FCCFECD, 32'h07199B9A, 32'h374CC0CD, 1, 4'b0010, "clamp", 1'b0);
    run(32'hBF800000, 32'hC0400000, 32'h40000000, 32'h80000001, 1, 4'b0100, "single", 1'b0);
    run(32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 64, 4'b0000, "tie_flush", 1'b0);
`ifdef MAXNET_ITER_CAP_EN
    run(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 64, 4'b1111, "tie_cap", 1'b0);
`endif
    run(32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD, 4, 4'b1000, "ramp_poke", 1'b1);

    #2 rst = 1'b0;
    #1;
    tests++;
    assert (done === 1'b0 && out === 4'b0000)
      else begin fails++; $error("FAIL reset_in_done done=%b out=%b expected done=0 out=0000", done, out); end
    @(negedge clk) rst = 1'b1;

    x_init_1 = 32'h3F4CCCCD; x_init_2 = 32'h3F19999A; x_init_3 = 32'h3ECCCCCD; x_init_4 = 32'h3E4CCCCD;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    assert (done === 1'b0 && out === 4'b0000)
      else begin fails++; $error("FAIL reset_mid_run done=%b out=%b expected done=0 out=0000", done, out); end
    @(negedge clk) rst = 1'b1;

    run(32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD, 4, 4'b1000, "after_reset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
